// File: rtl/butterfly_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// butterfly_sequencer_pkg
// Shared definitions for the radix-2 complex butterfly micro-sequencer:
//   - register-file addresses of operands, twiddle, temporaries and results
//   - micro-op selector encoding driven on op_code
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package butterfly_sequencer_pkg;

   // Register-file map
   localparam logic [3:0] REG_REW = 4'd0;   // twiddle, real
   localparam logic [3:0] REG_IMW = 4'd1;   // twiddle, imag
   localparam logic [3:0] REG_REB = 4'd2;   // input b, real
   localparam logic [3:0] REG_IMB = 4'd3;   // input b, imag
   localparam logic [3:0] REG_REA = 4'd4;   // input a, real
   localparam logic [3:0] REG_IMA = 4'd5;   // input a, imag
   localparam logic [3:0] REG_REY = 4'd6;   // output y = a + w*b, real
   localparam logic [3:0] REG_IMY = 4'd7;   // output y, imag
   localparam logic [3:0] REG_REZ = 4'd8;   // output z = a - w*b, real
   localparam logic [3:0] REG_IMZ = 4'd9;   // output z, imag
   localparam logic [3:0] REG_TRE = 4'd10;  // temporary w*b, real
   localparam logic [3:0] REG_TIM = 4'd11;  // temporary w*b, imag

   // Micro-op selector seen by the datapath
   typedef enum logic [2:0] {
      OP_MUL  = 3'd0,
      OP_MADD = 3'd1,
      OP_MSUB = 3'd2,
      OP_ADD  = 3'd3,
      OP_SUB  = 3'd4
   } op_t;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [2:0] LAST_STEP = 3'd7;

endpackage

// File: rtl/butterfly_step_rom.sv
// ---------------------------------------------------------------------------
// butterfly_step_rom
// Combinational micro-program for one complex butterfly. The accumulator in
// the datapath carries the product between a MUL step and the following
// MSUB/MADD step, so steps 0 and 2 write nothing back.
//   step     in  3  current micro-step
//   op       out 3  micro-op selector (op_t)
//   addr_a   out 4  operand A register
//   addr_b   out 4  operand B register
//   wb_en    out 1  step produces a register-file write
//   wb_addr  out 4  destination register (0 when wb_en=0)
// ---------------------------------------------------------------------------
module butterfly_step_rom
   import butterfly_sequencer_pkg::*;
(
   input  logic [2:0] step,
   output logic [2:0] op,
   output logic [3:0] addr_a,
   output logic [3:0] addr_b,
   output logic       wb_en,
   output logic [3:0] wb_addr
);

   op_t op_sel;

   always_comb begin
      op_sel  = OP_MUL;
      addr_a  = 4'd0;
      addr_b  = 4'd0;
      wb_en   = 1'b0;
      wb_addr = 4'd0;
      case (step)
         3'd0: begin op_sel = OP_MUL;  addr_a = REG_REW; addr_b = REG_REB; end
         3'd1: begin op_sel = OP_MSUB; addr_a = REG_IMW; addr_b = REG_IMB; wb_en = 1'b1; wb_addr = REG_TRE; end
         3'd2: begin op_sel = OP_MUL;  addr_a = REG_REW; addr_b = REG_IMB; end
         3'd3: begin op_sel = OP_MADD; addr_a = REG_IMW; addr_b = REG_REB; wb_en = 1'b1; wb_addr = REG_TIM; end
         3'd4: begin op_sel = OP_ADD;  addr_a = REG_REA; addr_b = REG_TRE; wb_en = 1'b1; wb_addr = REG_REY; end
         3'd5: begin op_sel = OP_ADD;  addr_a = REG_IMA; addr_b = REG_TIM; wb_en = 1'b1; wb_addr = REG_IMY; end
         3'd6: begin op_sel = OP_SUB;  addr_a = REG_REA; addr_b = REG_TRE; wb_en = 1'b1; wb_addr = REG_REZ; end
         default: begin op_sel = OP_SUB; addr_a = REG_IMA; addr_b = REG_TIM; wb_en = 1'b1; wb_addr = REG_IMZ; end
      endcase
      op = op_sel;
   end

endmodule

// File: rtl/butterfly_sequencer.sv
// ---------------------------------------------------------------------------
// butterfly_sequencer
// Steps a shared MAC datapath through the 8 micro-ops of one complex
// butterfly (y = a + w*b, z = a - w*b), handshaking each op with op_done and
// strobing register-file write-backs. A watchdog aborts a run whose op never
// completes.
//   clk        in  1  rising-edge clock
//   rst        in  1  asynchronous active-low reset
//   start      in  1  run request (level), accepted in IDLE once seen low
//   op_done    in  1  datapath result-ready pulse
//   op_valid   out 1  micro-op issued, held until op_done
//   op_code    out 3  micro-op selector (op_t)
//   rd_addr_a  out 4  operand A read address
//   rd_addr_b  out 4  operand B read address
//   wb_en      out 1  write-back strobe
//   wb_addr    out 4  write-back address
//   busy       out 1  sequencer not idle
//   done       out 1  run complete pulse
//   err        out 1  watchdog timeout pulse
// ---------------------------------------------------------------------------
module butterfly_sequencer
   import butterfly_sequencer_pkg::*;
#(
   parameter int WDOG_MAX = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       op_done,
   output logic       op_valid,
   output logic [2:0] op_code,
   output logic [3:0] rd_addr_a,
   output logic [3:0] rd_addr_b,
   output logic       wb_en,
   output logic [3:0] wb_addr,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Timeout fires in the WAIT cycle whose count would reach WDOG_MAX.
   localparam logic [7:0] WDOG_LAST = 8'(WDOG_MAX - 1);

   state_t     state;
   logic [2:0] step;
   logic [7:0] wdog;
   logic       armed;   // start has been seen low in IDLE since last accept

   logic [2:0] rom_op;
   logic [3:0] rom_a;
   logic [3:0] rom_b;
   logic       rom_wb_en;
   logic [3:0] rom_wb_addr;

   butterfly_step_rom u_rom (
      .step    (step),
      .op      (rom_op),
      .addr_a  (rom_a),
      .addr_b  (rom_b),
      .wb_en   (rom_wb_en),
      .wb_addr (rom_wb_addr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         step     <= 3'd0;
         wdog     <= 8'd0;
         armed    <= 1'b0;
         op_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && armed) begin
                  state    <= ST_ISSUE;
                  step     <= 3'd0;
                  wdog     <= 8'd0;
                  armed    <= 1'b0;
                  op_valid <= 1'b1;
                  busy     <= 1'b1;
               end else if (!start) begin
                  armed <= 1'b1;
               end
            end
            ST_ISSUE: begin
               wdog <= 8'd0;
               if (op_done) begin
                  state    <= ST_WB;
                  op_valid <= 1'b0;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (op_done) begin
                  state    <= ST_WB;
                  op_valid <= 1'b0;
               end else if (wdog == WDOG_LAST) begin
                  state    <= ST_IDLE;
                  step     <= 3'd0;
                  wdog     <= 8'd0;
                  op_valid <= 1'b0;
                  busy     <= 1'b0;
                  err      <= 1'b1;
               end else begin
                  wdog <= wdog + 8'd1;
               end
            end
            ST_WB: begin
               if (step == LAST_STEP) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  step     <= step + 3'd1;
                  state    <= ST_ISSUE;
                  op_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               step  <= 3'd0;
               busy  <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               step     <= 3'd0;
               wdog     <= 8'd0;
               op_valid <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // Operand and write-back fields are forced to 0 outside their phases so
   // the register file sees a quiet bus between ops.
   logic in_op;
   assign in_op     = (state == ST_ISSUE) || (state == ST_WAIT);
   assign op_code   = in_op ? rom_op : 3'd0;
   assign rd_addr_a = in_op ? rom_a  : 4'd0;
   assign rd_addr_b = in_op ? rom_b  : 4'd0;
   assign wb_en     = (state == ST_WB) && rom_wb_en;
   assign wb_addr   = wb_en ? rom_wb_addr : 4'd0;

endmodule

// File: tb/tb_butterfly_sequencer.sv
// ---------------------------------------------------------------------------
// tb_butterfly_sequencer
// Builds a cycle-by-cycle trace of stimulus and expected outputs from the
// butterfly micro-program and the handshake/latency rules, then plays it into
// the sequencer, comparing every output every cycle. Literal checks on logged
// DUT activity pin the trace builder itself.
// ---------------------------------------------------------------------------
module tb_butterfly_sequencer;

   localparam int WD = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       op_done = 1'b0;
   logic       op_valid;
   logic [2:0] op_code;
   logic [3:0] rd_addr_a;
   logic [3:0] rd_addr_b;
   logic       wb_en;
   logic [3:0] wb_addr;
   logic       busy;
   logic       done;
   logic       err;

   butterfly_sequencer #(.WDOG_MAX(WD)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_done   (op_done),
      .op_valid  (op_valid),
      .op_code   (op_code),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Butterfly micro-program: op, A, B, write?, destination
   int tab_op [8] = '{0, 2, 0, 1, 3, 3, 4, 4};
   int tab_a  [8] = '{0, 1, 0, 1, 4, 5, 4, 5};
   int tab_b  [8] = '{2, 3, 3, 2, 10, 11, 10, 11};
   int tab_we [8] = '{0, 1, 0, 1, 1, 1, 1, 1};
   int tab_wa [8] = '{0, 10, 0, 11, 6, 7, 8, 9};

   typedef struct packed {
      logic        st;
      logic        od;
      logic        rn;
      logic [19:0] exp;
   } cyc_t;

   cyc_t q[$];
   bit   armed_m;
   int   trig_idx;

   int   total = 0;
   int   bad   = 0;

   // Logs of DUT activity from the last played trace
   int   wb_log[$];
   int   vrun[$];
   int   done_at;
   int   err_at;
   int   done_cnt;

   function automatic logic [19:0] ev(logic v, int op, int a, int b, logic we,
                                      int wa, logic bz, logic dn, logic er);
      return {v, 3'(op), 4'(a), 4'(b), we, 4'(wa), bz, dn, er};
   endfunction

   task automatic add(logic st, logic od, logic rn, logic [19:0] e);
      cyc_t c;
      c.st = st; c.od = od; c.rn = rn; c.exp = e;
      q.push_back(c);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // IDLE cycles: mode 0 start low, 1 start high, 2 random start that never
   // triggers a run. op_done is random noise here.
   task automatic gen_idle(int n, int mode);
      logic st;
      for (int i = 0; i < n; i++) begin
         st = (mode == 1) ? 1'b1 : (mode == 2) ? rbit() : 1'b0;
         if (st && armed_m) st = 1'b0;
         add(st, rbit(), 1'b1, '0);
         if (!st) armed_m = 1'b1;
      end
   endtask

   task automatic gen_reset(int n);
      for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, '0);
      armed_m = 1'b0;
   endtask

   // One run. d[s] = cycles op_done is withheld at step s. to_step: step whose
   // op_done never comes (-1 none). rst_step/rst_k: reset during step rst_step
   // at its rst_k-th op_valid cycle (-1 none).
   task automatic gen_run(int d[8], bit hold, int to_step, int rst_step, int rst_k);
      logic st;
      trig_idx = q.size();
      add(1'b1, rbit(), 1'b1, '0);
      armed_m = 1'b0;
      for (int s = 0; s < 8; s++) begin
         if (s == to_step) begin
            for (int k = 0; k <= WD; k++)
               add(hold ? 1'b1 : rbit(), 1'b0, 1'b1,
                   ev(1, tab_op[s], tab_a[s], tab_b[s], 0, 0, 1, 0, 0));
            st = hold;
            add(st, rbit(), 1'b1, ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
            if (!st) armed_m = 1'b1;
            return;
         end
         for (int k = 0; k <= d[s]; k++) begin
            if (s == rst_step && k == rst_k) begin
               gen_reset(2);
               return;
            end
            add(hold ? 1'b1 : rbit(), (k == d[s]), 1'b1,
                ev(1, tab_op[s], tab_a[s], tab_b[s], 0, 0, 1, 0, 0));
         end
         add(hold ? 1'b1 : rbit(), rbit(), 1'b1,
             ev(0, 0, 0, 0, tab_we[s] != 0, (tab_we[s] != 0) ? tab_wa[s] : 0, 1, 0, 0));
      end
      add(hold ? 1'b1 : rbit(), rbit(), 1'b1, ev(0, 0, 0, 0, 0, 0, 1, 1, 0));
   endtask

   // Plays the trace and compares every cycle.
   task automatic play();
      logic [19:0] got;
      int run;
      wb_log.delete(); vrun.delete();
      done_at = -1; err_at = -1; done_cnt = 0; run = 0;
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         rst = q[i].rn; start = q[i].st; op_done = q[i].od;
         #1;
         got = {op_valid, op_code, rd_addr_a, rd_addr_b, wb_en, wb_addr, busy, done, err};
         total++;
         if (got !== q[i].exp) begin
            bad++;
            $display("FAIL cycle%0d outputs got=%05h want=%05h (valid,op,a,b,we,wa,busy,done,err)",
                     i, got, q[i].exp);
         end
         if (wb_en) wb_log.push_back(int'(wb_addr));
         if (done) begin done_at = i; done_cnt++; end
         if (err) err_at = i;
         if (op_valid) run++;
         else if (run != 0) begin vrun.push_back(run); run = 0; end
      end
      q.delete();
   endtask

   task automatic chk(string nm, int got, int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   initial begin
      int d[8];
      int wb_ref[6] = '{10, 11, 6, 7, 8, 9};
      armed_m = 1'b0;

      // Reset state and first run with immediate op_done
      gen_reset(3);
      gen_idle(2, 0);
      d = '{default: 0};
      gen_run(d, 1'b0, -1, -1, -1);
      gen_idle(2, 0);
      play();
      chk("start_to_done", done_at - trig_idx, 17);
      chk("wb_count", wb_log.size(), 6);
      for (int i = 0; i < 6; i++)
         chk("wb_addr_order", (i < wb_log.size()) ? wb_log[i] : -1, wb_ref[i]);

      // op_done three cycles late on every step
      gen_idle(1, 0);
      d = '{default: 3};
      gen_run(d, 1'b0, -1, -1, -1);
      gen_idle(2, 0);
      play();
      chk("valid_runs", vrun.size(), 8);
      for (int i = 0; i < vrun.size(); i++) chk("valid_len", vrun[i], 4);
      chk("slow_start_to_done", done_at - trig_idx, 17 + 8 * 3);

      // op_done withheld at step 2
      gen_idle(1, 0);
      foreach (d[i]) d[i] = $urandom_range(0, 3);
      gen_run(d, 1'b0, 2, -1, -1);
      gen_idle(3, 0);
      play();
      chk("timeout_valid_len", (vrun.size() == 3) ? vrun[2] : -1, 256);
      chk("timeout_wb_count", wb_log.size(), 1);
      chk("timeout_done_cnt", done_cnt, 0);
      chk("timeout_err_seen", (err_at >= 0) ? 1 : 0, 1);

      // Reset in WAIT of step 5, then a clean restart
      gen_idle(1, 0);
      foreach (d[i]) d[i] = $urandom_range(0, 3);
      d[5] = 4;
      gen_run(d, 1'b0, -1, 5, 2);
      gen_idle(2, 0);
      d = '{default: 0};
      gen_run(d, 1'b0, -1, -1, -1);
      gen_idle(1, 0);
      play();
      chk("restart_wb_count", wb_log.size(), 3 + 6);

      // start held high through DONE, spurious op_done in IDLE
      gen_idle(1, 0);
      foreach (d[i]) d[i] = $urandom_range(0, 2);
      gen_run(d, 1'b1, -1, -1, -1);
      gen_idle(6, 1);
      gen_idle(1, 0);
      gen_run(d, 1'b1, -1, -1, -1);
      gen_idle(2, 0);
      play();
      chk("held_start_done_cnt", done_cnt, 2);

      // Randomised runs with start/op_done noise
      for (int r = 0; r < 12; r++) begin
         gen_idle($urandom_range(0, 3), 2);
         gen_idle(1, 0);
         foreach (d[i]) d[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 3);
         gen_run(d, 1'b0, -1, -1, -1);
         gen_idle($urandom_range(1, 3), 2);
      end
      play();
      chk("random_done_cnt", done_cnt, 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
